// File: rtl/dcache_bus_fsm_pkg.sv
// dcache_bus_fsm_pkg: shared types and AHB encodings for the dcache bus master.
//   bus_state_e   : burst FSM states (READY, FETCH, WRITEBACK, ACK)
//   HTRANS_*      : AHB transfer-type encodings
//   HBURST_*      : AHB incrementing burst encodings
//   burst_type()  : maps beats-per-line onto the matching fixed INCRn burst,
//                   falling back to undefined-length INCR for other lengths
package dcache_bus_fsm_pkg;

  typedef enum logic [1:0] {
    READY     = 2'd0,
    FETCH     = 2'd1,
    WRITEBACK = 2'd2,
    ACK       = 2'd3
  } bus_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  function automatic logic [2:0] burst_type(input int beats);
    case (beats)
      4:       return HBURST_INCR4;
      8:       return HBURST_INCR8;
      16:      return HBURST_INCR16;
      default: return HBURST_INCR;
    endcase
  endfunction

endpackage

// File: rtl/dcache_bus_beatcnt.sv
// dcache_bus_beatcnt: saturating beat counter with clear and enable.
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous clear (wins over en)
//   en         : advance by one, holding once MAX is reached
//   cnt        : current count, WIDTH bits
module dcache_bus_beatcnt #(
  parameter int WIDTH = 3,
  parameter int MAX   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset || clr)            cnt <= '0;
    else if (en && cnt != MAX_V) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dcache_bus_fsm.sv
// dcache_bus_fsm: AHB INCR burst master between the data cache and the bus.
// Turns a line fetch / writeback request into one burst, assembles refill
// beats into FetchBuffer, streams victim words from the cache onto HWDATA,
// and answers with a single-cycle CacheBusAck.
//   Cache side : Flush, CacheBusRW[1]=fetch / [0]=writeback, CacheBusAdr,
//                ReadDataWord (word selected by BeatCount last cycle),
//                CacheBusAck, SelBusBeat, BeatCount, FetchBuffer
//   Pipeline   : BusCommitted (burst in flight), BusStall
//   AHB        : HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HRDATA, HREADY
// Optional build macro DCACHE_BUS_PERF_EN adds RefillCount / WritebackCount,
// 32-bit wrapping counts of completed fetches and writebacks.
module dcache_bus_fsm
  import dcache_bus_fsm_pkg::*;
#(
  parameter int PA_BITS      = 56,
  parameter int AHBW         = 64,
  parameter int LINELEN      = 512,
  parameter int BEATSPERLINE = LINELEN / AHBW,
  parameter int BEATBITS     = $clog2(BEATSPERLINE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Flush,
  input  logic [1:0]          CacheBusRW,
  input  logic [PA_BITS-1:0]  CacheBusAdr,
  input  logic [AHBW-1:0]     ReadDataWord,
  output logic                CacheBusAck,
  output logic                SelBusBeat,
  output logic [BEATBITS-1:0] BeatCount,
  output logic [LINELEN-1:0]  FetchBuffer,
  output logic                BusCommitted,
  output logic                BusStall,
`ifdef DCACHE_BUS_PERF_EN
  output logic [31:0]         RefillCount,
  output logic [31:0]         WritebackCount,
`endif
  output logic [PA_BITS-1:0]  HADDR,
  output logic [1:0]          HTRANS,
  output logic                HWRITE,
  output logic [2:0]          HSIZE,
  output logic [2:0]          HBURST,
  output logic [AHBW-1:0]     HWDATA,
  input  logic [AHBW-1:0]     HRDATA,
  input  logic                HREADY
);

  localparam int BEATOFF = $clog2(AHBW / 8);
  localparam int LINEOFF = $clog2(LINELEN / 8);
  localparam logic [PA_BITS-1:0]  LINE_MASK = ~(PA_BITS'(LINELEN / 8 - 1));
  localparam logic [BEATBITS:0]   ADR_END   = BEATSPERLINE[BEATBITS:0];
  localparam logic [BEATBITS-1:0] LAST_BEAT = BEATBITS'(BEATSPERLINE - 1);
  localparam logic [2:0]          HSIZE_V   = 3'(BEATOFF);
  localparam logic [2:0]          HBURST_V  = burst_type(BEATSPERLINE);

  bus_state_e            state, next_state;
  logic [BEATBITS:0]     adr_beat;   // one extra bit so it can rest at BEATSPERLINE
  logic [BEATBITS-1:0]   data_beat;
  logic [PA_BITS-1:0]    line_base;
  logic [LINEOFF-1:0]    beat_off;
  logic                  req, busy, start;

  assign req      = (CacheBusRW != 2'b00) && !Flush;
  assign busy     = (state == FETCH) || (state == WRITEBACK);
  assign start    = (state == READY) && req && HREADY;
  assign beat_off = {adr_beat[BEATBITS-1:0], {BEATOFF{1'b0}}};

  // Address-phase beat: starts at 1 once the NONSEQ is accepted.
  dcache_bus_beatcnt #(.WIDTH(BEATBITS + 1), .MAX(BEATSPERLINE)) u_adr_beat (
    .clk   (clk),
    .reset (reset),
    .clr   (!busy && !start),
    .en    (start || (busy && HREADY)),
    .cnt   (adr_beat)
  );

  // Data-phase beat: trails the address beat by one accepted transfer.
  dcache_bus_beatcnt #(.WIDTH(BEATBITS), .MAX(BEATSPERLINE - 1)) u_data_beat (
    .clk   (clk),
    .reset (reset),
    .clr   (!busy),
    .en    (busy && HREADY),
    .cnt   (data_beat)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= READY;
    else       state <= next_state;
  end

  // Latch the line base so the cache may move CacheBusAdr mid-burst.
  always_ff @(posedge clk) begin
    if (reset)      line_base <= '0;
    else if (start) line_base <= CacheBusAdr & LINE_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset)                             FetchBuffer <= '0;
    else if (state == FETCH && HREADY)     FetchBuffer[data_beat*AHBW +: AHBW] <= HRDATA;
  end

  always_comb begin
    next_state   = state;
    HTRANS       = HTRANS_IDLE;
    HADDR        = '0;
    HWRITE       = 1'b0;
    SelBusBeat   = 1'b0;
    BusStall     = 1'b0;
    BusCommitted = 1'b0;
    CacheBusAck  = 1'b0;
    case (state)
      READY: begin
        if (req) begin
          HTRANS     = HTRANS_NONSEQ;
          HADDR      = CacheBusAdr & LINE_MASK;
          HWRITE     = CacheBusRW[0];
          SelBusBeat = CacheBusRW[0];
          BusStall   = 1'b1;
          if (HREADY) next_state = CacheBusRW[1] ? FETCH : WRITEBACK;
        end
      end
      FETCH, WRITEBACK: begin
        BusCommitted = 1'b1;
        BusStall     = 1'b1;
        // Held through the whole writeback so a stalled final data beat
        // still has the cache presenting its word.
        SelBusBeat   = (state == WRITEBACK);
        if (adr_beat < ADR_END) begin
          HTRANS = HTRANS_SEQ;
          HADDR  = line_base | PA_BITS'(beat_off);
          HWRITE = (state == WRITEBACK);
        end
        if (HREADY && data_beat == LAST_BEAT) next_state = ACK;
      end
      ACK: begin
        BusCommitted = 1'b1;
        CacheBusAck  = 1'b1;
        next_state   = READY;
      end
      default: next_state = READY;
    endcase
  end

  // The cache registers the word picked here, so HWDATA next cycle must be
  // the word of the beat whose data phase is then pending. While HREADY is
  // low the pending data beat does not move, so point the cache back at it.
  assign BeatCount = (state == WRITEBACK && !HREADY) ? data_beat : adr_beat[BEATBITS-1:0];

  assign HWDATA = (state == WRITEBACK) ? ReadDataWord : '0;
  assign HSIZE  = (HTRANS != HTRANS_IDLE) ? HSIZE_V  : 3'b000;
  assign HBURST = (HTRANS != HTRANS_IDLE) ? HBURST_V : 3'b000;

`ifdef DCACHE_BUS_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      RefillCount    <= '0;
      WritebackCount <= '0;
    end else if (busy && next_state == ACK) begin
      if (state == FETCH) RefillCount    <= RefillCount + 32'd1;
      else                WritebackCount <= WritebackCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_bus_fsm.sv
// tb_dcache_bus_fsm: scoreboard bench for dcache_bus_fsm (8-beat, 64-bit bus).
// Expected address phases and write words are queued when a burst is
// launched and popped as the DUT presents them; a small AHB slave and a
// one-cycle-latency cache model sit around the DUT.
module tb_dcache_bus_fsm;
  import dcache_bus_fsm_pkg::*;

  localparam int PA = 56, W = 64, LL = 512, BEATS = 8, BB = 3;

  logic            clk = 1'b0;
  logic            reset, Flush, HREADY;
  logic [1:0]      CacheBusRW;
  logic [PA-1:0]   CacheBusAdr;
  logic [W-1:0]    ReadDataWord = '0;
  logic [W-1:0]    HRDATA;
  logic            CacheBusAck, SelBusBeat, BusCommitted, BusStall, HWRITE;
  logic [BB-1:0]   BeatCount;
  logic [LL-1:0]   FetchBuffer;
  logic [PA-1:0]   HADDR;
  logic [1:0]      HTRANS;
  logic [2:0]      HSIZE, HBURST;
  logic [W-1:0]    HWDATA;
`ifdef DCACHE_BUS_PERF_EN
  logic [31:0]     RefillCount, WritebackCount;
`endif

  int checks = 0, errors = 0;
  int n_refill = 0, n_wb = 0;

  typedef struct {
    logic [PA-1:0] addr;
    logic [1:0]    trans;
    int            beat;
  } aph_t;

  aph_t         exp_aph_q[$];
  logic [W-1:0] exp_wd_q[$];
  logic [W-1:0] wb_words[BEATS];

  dcache_bus_fsm dut (
    .clk(clk), .reset(reset), .Flush(Flush), .CacheBusRW(CacheBusRW),
    .CacheBusAdr(CacheBusAdr), .ReadDataWord(ReadDataWord),
    .CacheBusAck(CacheBusAck), .SelBusBeat(SelBusBeat), .BeatCount(BeatCount),
    .FetchBuffer(FetchBuffer), .BusCommitted(BusCommitted), .BusStall(BusStall),
`ifdef DCACHE_BUS_PERF_EN
    .RefillCount(RefillCount), .WritebackCount(WritebackCount),
`endif
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
  );

  always #5 clk = ~clk;

  // Cache model: word selected by BeatCount appears one cycle later.
  always @(posedge clk) if (SelBusBeat) ReadDataWord <= wb_words[BeatCount];

  always @(posedge clk)
    if (!reset && CacheBusRW == 2'b11) begin
      errors++;
      $display("FAIL illegal_rw: CacheBusRW=%b, both bits may not be set", CacheBusRW);
    end

  function automatic logic [W-1:0] rd_pat(input int seed, input int b);
    return {32'(seed), 32'hC0DE_0000 + 32'(b)};
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    CacheBusRW = 2'b00; Flush = 1'b0; HREADY = 1'b1; HRDATA = '0;
    #1;
  endtask

  // Runs one burst to its ack, comparing every address/data phase against
  // the scoreboard. ack_cyc is the cycle index of the ack, request = cycle 0.
  task automatic run_burst(input logic [1:0] rw, input logic [PA-1:0] adr,
                           input int stall_at, input int stall_len,
                           input int flush_at, input int seed, output int ack_cyc);
    logic dp_v;
    int   dp_b;
    aph_t e;
    logic [W-1:0] wd;
    dp_v = 1'b0; dp_b = 0; ack_cyc = -1;
    for (int b = 0; b < BEATS; b++) begin
      e.addr  = {adr[PA-1:6], 6'b0} + PA'(b * 8);
      e.trans = (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      e.beat  = b;
      exp_aph_q.push_back(e);
      if (rw[0]) exp_wd_q.push_back(wb_words[b]);
    end
    for (int c = 0; c < 60 && ack_cyc < 0; c++) begin
      @(negedge clk);
      CacheBusRW  = rw;
      CacheBusAdr = adr;
      Flush       = (c == flush_at);
      HREADY      = !(c >= stall_at && c < stall_at + stall_len);
      HRDATA      = dp_v ? rd_pat(seed, dp_b) : '0;
      #1;
      checks++;
      if (exp_aph_q.size() > 0) begin
        if (HTRANS !== exp_aph_q[0].trans || HADDR !== exp_aph_q[0].addr) begin
          errors++;
          $display("FAIL addr_phase c=%0d: got %b/%h want %b/%h", c, HTRANS, HADDR,
                   exp_aph_q[0].trans, exp_aph_q[0].addr);
        end
        checks++;
        if (HWRITE !== rw[0]) begin
          errors++; $display("FAIL hwrite c=%0d: got %b want %b", c, HWRITE, rw[0]);
        end
        if (exp_aph_q[0].trans == HTRANS_NONSEQ) begin
          checks++;
          if (HBURST !== 3'b101 || HSIZE !== 3'b011) begin
            errors++; $display("FAIL burst_size: got %b/%b want 101/011", HBURST, HSIZE);
          end
        end
        if (rw[0] && HREADY) begin
          checks++;
          if (SelBusBeat !== 1'b1 || BeatCount !== BB'(exp_aph_q[0].beat)) begin
            errors++;
            $display("FAIL beatcount c=%0d: got sel=%b cnt=%0d want sel=1 cnt=%0d", c,
                     SelBusBeat, BeatCount, exp_aph_q[0].beat);
          end
        end
      end else if (HTRANS !== HTRANS_IDLE) begin
        errors++; $display("FAIL idle_after_last c=%0d: got %b want 00", c, HTRANS);
      end
      if (dp_v && HREADY && rw[0]) begin
        wd = exp_wd_q.pop_front();
        checks++;
        if (HWDATA !== wd) begin
          errors++; $display("FAIL hwdata beat=%0d: got %h want %h", dp_b, HWDATA, wd);
        end
      end
      if (CacheBusAck === 1'b1) ack_cyc = c;
      checks++;
      if (BusCommitted !== (c != 0) || BusStall !== (ack_cyc < 0)) begin
        errors++;
        $display("FAIL status c=%0d: got commit=%b stall=%b want commit=%b stall=%b", c,
                 BusCommitted, BusStall, c != 0, ack_cyc < 0);
      end
      if (HREADY) begin
        if (exp_aph_q.size() > 0 && HTRANS !== HTRANS_IDLE) begin
          dp_v = 1'b1;
          dp_b = exp_aph_q[0].beat;
          void'(exp_aph_q.pop_front());
        end else dp_v = 1'b0;
      end
    end
    checks++;
    if (ack_cyc < 0 || exp_aph_q.size() != 0 || exp_wd_q.size() != 0) begin
      errors++;
      $display("FAIL burst_end: got ack_cyc=%0d aph_left=%0d wd_left=%0d want ack, 0, 0",
               ack_cyc, exp_aph_q.size(), exp_wd_q.size());
    end
    exp_aph_q.delete();
    exp_wd_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; Flush = 1'b0; CacheBusRW = 2'b00; CacheBusAdr = '0;
    HREADY = 1'b1; HRDATA = '0;
    for (int i = 0; i < BEATS; i++) wb_words[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (HTRANS !== HTRANS_IDLE || HADDR !== '0 || HWRITE !== 1'b0 || HBURST !== 3'b0 ||
        HSIZE !== 3'b0 || HWDATA !== '0 || CacheBusAck !== 1'b0 || BusCommitted !== 1'b0 ||
        BusStall !== 1'b0 || SelBusBeat !== 1'b0 || BeatCount !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got trans=%b addr=%h ack=%b commit=%b stall=%b want all 0",
               HTRANS, HADDR, CacheBusAck, BusCommitted, BusStall);
    end
    checks++;
    if (FetchBuffer !== '0) begin
      errors++; $display("FAIL reset_fetchbuf: got %h want 0", FetchBuffer);
    end
    reset = 1'b0;
  endtask

  task automatic check_line(input string name, input int seed);
    logic [LL-1:0] line;
    for (int b = 0; b < BEATS; b++) line[b*W +: W] = rd_pat(seed, b);
    checks++;
    if (FetchBuffer !== line) begin
      errors++; $display("FAIL %s: got %h want %h", name, FetchBuffer, line);
    end
  endtask

  task automatic check_ack_cycle(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s: got ack at cycle %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_refill();
    int ack;
    run_burst(2'b10, 56'h8000_0040, 99, 0, -1, 1, ack);
    n_refill++;
    // Request in cycle 0 (the first of ten cycles), ack in cycle 9.
    check_ack_cycle("refill_ack", ack, 9);
    idle_cycle();
    check_line("refill_line", 1);
    checks++;
    if (CacheBusAck !== 1'b0 || BusCommitted !== 1'b0) begin
      errors++; $display("FAIL refill_ack_len: got ack=%b commit=%b want 0 0", CacheBusAck, BusCommitted);
    end
  endtask

  task automatic test_writeback();
    int ack;
    for (int i = 0; i < BEATS; i++) wb_words[i] = 64'(8'h11 * (i + 1));
    run_burst(2'b01, 56'h1234_5680, 99, 0, -1, 0, ack);
    n_wb++;
    check_ack_cycle("wb_ack", ack, 9);
    idle_cycle();
    checks++;
    if (CacheBusAck !== 1'b0 || HTRANS !== HTRANS_IDLE) begin
      errors++; $display("FAIL wb_ack_len: got ack=%b trans=%b want 0 00", CacheBusAck, HTRANS);
    end
  endtask

  task automatic test_wait_states();
    int ack;
    run_burst(2'b10, 56'h0000_0F00, 3, 2, -1, 7, ack);
    n_refill++;
    check_ack_cycle("wait_fetch_ack", ack, 11);
    idle_cycle();
    check_line("wait_fetch_line", 7);
    for (int i = 0; i < BEATS; i++) wb_words[i] = 64'hAB00 + 64'(i);
    run_burst(2'b01, 56'h0000_2A40, 3, 2, -1, 0, ack);
    n_wb++;
    check_ack_cycle("wait_wb_ack", ack, 11);
    idle_cycle();
  endtask

  task automatic test_flush();
    int ack;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      CacheBusRW = 2'b10; CacheBusAdr = 56'h4000_0000; Flush = 1'b1; HREADY = 1'b1;
      #1;
      checks++;
      if (HTRANS !== HTRANS_IDLE || BusStall !== 1'b0 || BusCommitted !== 1'b0) begin
        errors++;
        $display("FAIL flush_ready: got trans=%b stall=%b commit=%b want 00 0 0",
                 HTRANS, BusStall, BusCommitted);
      end
    end
    run_burst(2'b10, 56'h4000_0080, 99, 0, 4, 3, ack);
    n_refill++;
    check_ack_cycle("flush_mid_ack", ack, 9);
    idle_cycle();
    check_line("flush_mid_line", 3);
  endtask

  task automatic test_back_to_back();
    int ack1, ack2;
    for (int i = 0; i < BEATS; i++) wb_words[i] = 64'hFEED_0000 + 64'(i);
    run_burst(2'b01, 56'h0010_0000, 99, 0, -1, 0, ack1);
    run_burst(2'b10, 56'h0010_0000, 99, 0, -1, 5, ack2);
    n_wb++; n_refill++;
    check_ack_cycle("b2b_ack1", ack1, 9);
    check_ack_cycle("b2b_ack2", ack2, 9);
    idle_cycle();
    check_line("b2b_line", 5);
`ifdef DCACHE_BUS_PERF_EN
    checks++;
    if (RefillCount !== 32'(n_refill) || WritebackCount !== 32'(n_wb)) begin
      errors++;
      $display("FAIL perf_counts: got %0d/%0d want %0d/%0d", RefillCount, WritebackCount,
               n_refill, n_wb);
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      CacheBusRW = 2'b10; CacheBusAdr = 56'h0000_7000; Flush = 1'b0; HREADY = 1'b1;
      HRDATA = rd_pat(9, c);
    end
    @(negedge clk);
    reset = 1'b1; CacheBusRW = 2'b00; HRDATA = '0;
    @(negedge clk);
    #1;
    checks++;
    if (HTRANS !== HTRANS_IDLE || BusCommitted !== 1'b0 || CacheBusAck !== 1'b0 ||
        FetchBuffer !== '0) begin
      errors++;
      $display("FAIL reset_mid: got trans=%b commit=%b ack=%b want 00 0 0, buffer clear",
               HTRANS, BusCommitted, CacheBusAck);
    end
`ifdef DCACHE_BUS_PERF_EN
    checks++;
    if (RefillCount !== 32'd0 || WritebackCount !== 32'd0) begin
      errors++; $display("FAIL perf_reset: got %0d/%0d want 0/0", RefillCount, WritebackCount);
    end
`endif
    reset = 1'b0;
    idle_cycle();
    checks++;
    if (CacheBusAck !== 1'b0 || BusCommitted !== 1'b0) begin
      errors++; $display("FAIL reset_mid_noack: got ack=%b commit=%b want 0 0", CacheBusAck, BusCommitted);
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_writeback();
    test_wait_states();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
